// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: valid/ready operand and result bus for pipelined_adder.
// Carries the sub control only when ADDER_SUB_EN is defined.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
`ifdef ADDER_SUB_EN
    logic             sub;
    modport master (output in_valid, a, b, cin, sub, out_ready, input in_ready, out_valid, sum, cout, ovf);
    modport slave  (input in_valid, a, b, cin, sub, out_ready, output in_ready, out_valid, sum, cout, ovf);
`else
    modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout, ovf);
    modport slave  (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout, ovf);
`endif
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: ripple-carry adder split into STAGES slices, one slice per stage, valid/ready flow control.
// Optional ADDER_SUB_EN adds a sub input (a - b - cin) that is folded into b and cin at entry.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic clk,
    input logic rst,
    pipelined_adder_if.slave bus
);
    localparam int SW = WIDTH / STAGES;
    logic              advance;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] c;
    // [stage][slice]: operands skew down the pipe, finished sum slices travel alongside
    logic [SW-1:0]     a_sl [STAGES][STAGES];
    logic [SW-1:0]     b_sl [STAGES][STAGES];
    logic [SW-1:0]     s_sl [STAGES][STAGES];
`ifdef ADDER_SUB_EN
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.cin ^ bus.sub;
`else
    assign b_eff   = bus.b;
    assign cin_eff = bus.cin;
`endif
    assign advance       = bus.out_ready | ~v[STAGES-1];
    assign bus.in_ready  = advance;
    assign bus.out_valid = v[STAGES-1];
    assign bus.cout      = c[STAGES-1];
    assign bus.ovf       = (a_sl[STAGES-1][STAGES-1][SW-1] == b_sl[STAGES-1][STAGES-1][SW-1]) &
                           (s_sl[STAGES-1][STAGES-1][SW-1] != a_sl[STAGES-1][STAGES-1][SW-1]);
    for (genvar j = 0; j < STAGES; j++) begin : g_out
        assign bus.sum[j*SW +: SW] = s_sl[STAGES-1][j];
    end
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0] ai [STAGES];
        logic [SW-1:0] bi [STAGES];
        logic [SW-1:0] si [STAGES];
        logic [SW-1:0] so [STAGES];
        logic          ci;
        logic          vi;
        logic [SW:0]   r;
        if (k == 0) begin : g_in
            for (genvar j = 0; j < STAGES; j++) begin : g_s
                assign ai[j] = bus.a[j*SW +: SW];
                assign bi[j] = b_eff[j*SW +: SW];
                assign si[j] = '0;
            end
            assign ci = cin_eff;
            assign vi = bus.in_valid;
        end else begin : g_pipe
            assign ai = a_sl[k-1];
            assign bi = b_sl[k-1];
            assign si = s_sl[k-1];
            assign ci = c[k-1];
            assign vi = v[k-1];
        end
        assign r = {1'b0, ai[k]} + {1'b0, bi[k]} + {{SW{1'b0}}, ci};
        always_comb begin
            so    = si;
            so[k] = r[SW-1:0];
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                v[k]    <= 1'b0;
                c[k]    <= 1'b0;
                a_sl[k] <= '{default: '0};
                b_sl[k] <= '{default: '0};
                s_sl[k] <= '{default: '0};
            end else if (advance) begin
                v[k]    <= vi;
                c[k]    <= r[SW];
                a_sl[k] <= ai;
                b_sl[k] <= bi;
                s_sl[k] <= so;
            end
        end
    end
endmodule
